// File: rtl/upsample2d_nn.sv
// upsample2d_nn
//   Streaming 2x nearest-neighbour upsampler. An IN_W x IN_H raster map is
//   expanded to 2*IN_W x 2*IN_H by turning every pixel into a 2x2 block.
//   The first output row of each pair is produced from the live input. Each
//   pixel is emitted twice from a hold register and is also stored in a line
//   buffer. The second output row is then replayed from that line buffer.
//   Pixels pass through unchanged (signed, no clamping).
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_start      starts one frame, sampled only while idle
//   i_data       input pixel, raster order
//   i_valid      i_data valid
//   o_in_ready   input accepted this cycle when i_valid is also high
//   o_data       output pixel, raster order of the expanded map
//   o_valid      o_data valid
//   i_out_ready  downstream accepts o_data
//   o_busy       high whenever a frame is in progress
//   o_done       one-cycle pulse after the final output transfer
module upsample2d_nn #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_W       = 3,
  parameter int IN_H       = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_in_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int XW = $clog2(IN_W) + 1;
  localparam int YW = $clog2(IN_H) + 1;
  localparam int AW = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROW_A = 2'd1;
  localparam logic [1:0] ROW_B = 2'd2;

  logic [1:0]            state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  phase;
  logic                  held;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] line_buf [IN_W];
  logic                  done_q;

  logic                  last_x;
  logic                  last_y;
  logic [AW-1:0]         x_idx;
  logic [AW-1:0]         wr_idx;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  in_fire;
  logic                  out_fire;

  always_comb begin
    last_x    = (x == XW'(IN_W - 1));
    last_y    = (y == YW'(IN_H - 1));
    x_idx     = x[AW-1:0];
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = hold;
    case (state)
      ROW_A: begin
        // The bypass term lets the next pixel arrive together with the second
        // beat of the current one. It is blocked on the last column so that
        // the row boundary never overlaps with ROW_B.
        in_ready  = !held | (held & phase & i_out_ready & !last_x);
        out_valid = held;
        out_data  = hold;
      end
      ROW_B: begin
        out_valid = 1'b1;
        out_data  = line_buf[x_idx];
      end
      default: ;
    endcase
    in_fire  = i_valid & in_ready;
    out_fire = out_valid & i_out_ready;
    // An accept while still holding is always a bypass. At that moment x is
    // still the outgoing pixel's column, so the new pixel goes into the next slot.
    wr_idx   = held ? (x_idx + AW'(1)) : x_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      phase    <= 1'b0;
      held     <= 1'b0;
      hold     <= '0;
      line_buf <= '{default: '0};
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            x     <= '0;
            y     <= '0;
            phase <= 1'b0;
            held  <= 1'b0;
            state <= ROW_A;
          end
        end
        ROW_A: begin
          if (out_fire) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              held  <= 1'b0;
              if (last_x) begin
                x     <= '0;
                state <= ROW_B;
              end else begin
                x <= x + XW'(1);
              end
            end
          end
          if (in_fire) begin
            hold             <= i_data;
            line_buf[wr_idx] <= i_data;
            held             <= 1'b1;
            phase            <= 1'b0;
          end
        end
        ROW_B: begin
          if (out_fire) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (last_x) begin
                x <= '0;
                if (last_y) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                end else begin
                  y     <= y + YW'(1);
                  state <= ROW_A;
                end
              end else begin
                x <= x + XW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_in_ready = in_ready;
  assign o_valid    = out_valid;
  assign o_data     = out_data;
  assign o_busy     = (state != IDLE);
  assign o_done     = done_q;

endmodule
